// File: rtl/acc_pkg.sv
// Shared opcode, FSM-state and ALU-select encodings for the accumulator core.
// Also hosts the signed-overflow helper used by the add/sub datapath.
package acc_pkg;

  localparam int unsigned OPC_W_DEF  = 3;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_STORE = 3'd4,
    OP_JMP   = 3'd5,
    OP_JZ    = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ALU_NONE = 2'd0,
    ALU_PASS = 2'd1,
    ALU_ADD  = 2'd2,
    ALU_SUB  = 2'd3
  } alu_op_e;

  // Two's-complement overflow from operand/result sign bits (a - b when is_sub).
  function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                      input logic r_s, input logic is_sub);
    logic same_sign;
    same_sign = is_sub ? (a_s != b_s) : (a_s == b_s);
    return same_sign && (r_s != a_s);
  endfunction

endpackage

// File: rtl/acc_decode.sv
// Opcode decoder for acc_core: classifies the latched opcode into control flags.
// Opcodes outside the defined set behave as NOP.
module acc_decode
  import acc_pkg::*;
#(
  parameter int unsigned OPC_W = OPC_W_DEF
) (
  input  logic [OPC_W-1:0] opcode,
  output logic             is_mem,
  output logic             is_wr,
  output alu_op_e          alu_op,
  output logic             is_jmp,
  output logic             is_jz,
  output logic             is_halt
);

  always_comb begin
    is_mem  = 1'b0;
    is_wr   = 1'b0;
    alu_op  = ALU_NONE;
    is_jmp  = 1'b0;
    is_jz   = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OPC_W'(OP_LOAD): begin
        is_mem = 1'b1;
        alu_op = ALU_PASS;
      end
      OPC_W'(OP_ADD): begin
        is_mem = 1'b1;
        alu_op = ALU_ADD;
      end
      OPC_W'(OP_SUB): begin
        is_mem = 1'b1;
        alu_op = ALU_SUB;
      end
      OPC_W'(OP_STORE): begin
        is_mem = 1'b1;
        is_wr  = 1'b1;
      end
      OPC_W'(OP_JMP):  is_jmp  = 1'b1;
      OPC_W'(OP_JZ):   is_jz   = 1'b1;
      OPC_W'(OP_HALT): is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// Single-accumulator multicycle core: FETCH -> EXEC -> (WAIT) with a
// request/acknowledge data-memory port held stable until acknowledged.
module acc_core
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPC_W+ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0]       instr_addr,
  output logic                    mem_req,
  output logic                    mem_wr,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data_out,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_data_in,
  output logic                    zero,
  output logic                    ovf,
  output logic                    halted
);

  localparam int unsigned IW = OPC_W + ADDR_W;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_acc;
  logic [IW-1:0]       r_ir;
  logic                r_ovf;
  logic                r_mem_req;
  logic                r_mem_wr;

  logic [OPC_W-1:0]    w_opc;
  logic [ADDR_W-1:0]   w_operand;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic                w_add_ovf;
  logic                w_sub_ovf;
  logic                w_acc_zero;
  logic                w_is_mem;
  logic                w_is_wr;
  alu_op_e             w_alu_op;
  logic                w_is_jmp;
  logic                w_is_jz;
  logic                w_is_halt;

  assign w_opc      = r_ir[IW-1 -: OPC_W];
  assign w_operand  = r_ir[ADDR_W-1:0];
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_acc_zero = (r_acc == '0);

  acc_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .opcode  (w_opc),
    .is_mem  (w_is_mem),
    .is_wr   (w_is_wr),
    .alu_op  (w_alu_op),
    .is_jmp  (w_is_jmp),
    .is_jz   (w_is_jz),
    .is_halt (w_is_halt)
  );

  // Wrapping add/sub with signed-overflow detection on the memory operand.
  assign w_sum     = r_acc + mem_data_in;
  assign w_diff    = r_acc - mem_data_in;
  assign w_add_ovf = signed_ovf(r_acc[DATA_W-1], mem_data_in[DATA_W-1],
                                w_sum[DATA_W-1], 1'b0);
  assign w_sub_ovf = signed_ovf(r_acc[DATA_W-1], mem_data_in[DATA_W-1],
                                w_diff[DATA_W-1], 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= '0;
      r_acc     <= '0;
      r_ir      <= '0;
      r_ovf     <= 1'b0;
      r_mem_req <= 1'b0;
      r_mem_wr  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_mem) begin
            r_mem_req <= 1'b1;
            r_mem_wr  <= w_is_wr;
            r_state   <= S_WAIT;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
          end else if (w_is_jmp) begin
            r_pc    <= w_operand;
            r_state <= S_FETCH;
          end else if (w_is_jz) begin
            r_pc    <= w_acc_zero ? w_operand : w_pc_inc;
            r_state <= S_FETCH;
          end else begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        S_WAIT: begin
          // Request, write flag, address and data stay frozen until ack.
          if (mem_ack) begin
            case (w_alu_op)
              ALU_PASS: r_acc <= mem_data_in;
              ALU_ADD: begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_add_ovf;
              end
              ALU_SUB: begin
                r_acc <= w_diff;
                r_ovf <= r_ovf | w_sub_ovf;
              end
              default: ;
            endcase
            r_pc      <= w_pc_inc;
            r_mem_req <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_state   <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign instr_addr   = r_pc;
  assign mem_req      = r_mem_req;
  assign mem_wr       = r_mem_wr;
  assign mem_addr     = w_operand;
  assign mem_data_out = r_acc;
  assign zero         = w_acc_zero;
  assign ovf          = r_ovf;
  assign halted       = (r_state == S_HALT);

endmodule

// File: tb/tb_acc_core.sv
// Directed self-checking bench for acc_core (8-bit data, 8-bit address) with a
// program ROM and a data-memory responder whose ack latency is programmable.
module tb_acc_core;
  import acc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned OW = 3;
  localparam int unsigned TIMEOUT = 200;

  logic          clk;
  logic          rst;
  logic [OW+AW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic          mem_ack;
  logic [DW-1:0] mem_data_in;
  logic          zero;
  logic          ovf;
  logic          halted;

  logic [OW+AW-1:0] rom [256];
  logic [DW-1:0]    dmem [256];
  int               ack_delay;
  int               wait_cnt;
  logic             spur_ack;
  int               n_cmp;
  int               n_err;
  int               cyc;

  acc_core #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .OPC_W  (OW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .instr_addr   (instr_addr),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_ack      (mem_ack),
    .mem_data_in  (mem_data_in),
    .zero         (zero),
    .ovf          (ovf),
    .halted       (halted)
  );

  assign instr = rom[instr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: acks after ack_delay WAIT cycles; optional spurious acks when idle.
  initial begin
    mem_ack     = 1'b0;
    mem_data_in = '0;
    wait_cnt    = 0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_wr) dmem[mem_addr] = mem_data_out;
          else        mem_data_in    = dmem[mem_addr];
        end
      end else begin
        wait_cnt = 0;
        if (spur_ack) begin
          mem_ack     = 1'b1;
          mem_data_in = 8'h55;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW+AW-1:0] op(input opcode_e o, input logic [AW-1:0] a);
    return {o, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = op(OP_HALT, 8'h00);
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, output int cycles);
    cycles = 0;
    while (!halted && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    check(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    spur_ack = 1'b0;
    ack_delay = 0;
    rst      = 1'b1;
    clear_mems();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_pc",      32'(instr_addr),   32'd0);
    check("rst_req",     32'(mem_req),      32'd0);
    check("rst_wr",      32'(mem_wr),       32'd0);
    check("rst_zero",    32'(zero),         32'd1);
    check("rst_halted",  32'(halted),       32'd0);
    check("rst_ovf",     32'(ovf),          32'd0);
    check("rst_acc",     32'(mem_data_out), 32'd0);

    // LOAD/ADD/STORE with same-cycle ack
    clear_mems();
    rom[0] = op(OP_LOAD, 8'h05);
    rom[1] = op(OP_ADD, 8'h06);
    rom[2] = op(OP_STORE, 8'h09);
    rom[3] = op(OP_HALT, 8'h00);
    dmem[5] = 8'd7;
    dmem[6] = 8'hFD;
    ack_delay = 0;
    do_reset();
    run_to_halt("las_halt", cyc);
    check("las_cycles", 32'(cyc),          32'd11);
    check("las_mem9",   32'(dmem[9]),      32'd4);
    check("las_pc",     32'(instr_addr),   32'd3);
    check("las_zero",   32'(zero),         32'd0);
    check("las_acc",    32'(mem_data_out), 32'd4);
    check("las_ovf",    32'(ovf),          32'd0);

    // LOAD with delayed ack
    clear_mems();
    rom[0] = op(OP_LOAD, 8'h05);
    dmem[5] = 8'h2A;
    ack_delay = 4;
    do_reset();
    tick();
    check("dly_req_fetch", 32'(mem_req), 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("dly_req",  32'(mem_req),      32'd1);
      check("dly_addr", 32'(mem_addr),     32'd5);
      check("dly_wr",   32'(mem_wr),       32'd0);
      check("dly_acc",  32'(mem_data_out), 32'd0);
      tick();
    end
    check("dly_req_done", 32'(mem_req),      32'd0);
    check("dly_acc_done", 32'(mem_data_out), 32'h2A);
    check("dly_pc",       32'(instr_addr),   32'd1);
    ack_delay = 0;

    // Add overflow then non-overflowing SUB keeps ovf sticky
    clear_mems();
    rom[0] = op(OP_LOAD, 8'h10);
    rom[1] = op(OP_ADD, 8'h11);
    rom[2] = op(OP_STORE, 8'h20);
    rom[3] = op(OP_SUB, 8'h12);
    rom[4] = op(OP_STORE, 8'h21);
    dmem[8'h10] = 8'h7F;
    dmem[8'h11] = 8'h01;
    dmem[8'h12] = 8'hFF;
    do_reset();
    run_to_halt("ovf_halt", cyc);
    check("ovf_cycles", 32'(cyc),            32'd17);
    check("ovf_sum",    32'(dmem[8'h20]),    32'h80);
    check("ovf_diff",   32'(dmem[8'h21]),    32'h81);
    check("ovf_flag",   32'(ovf),            32'd1);
    check("ovf_pc",     32'(instr_addr),     32'd5);

    // Subtract overflow: -128 - 1
    clear_mems();
    rom[0] = op(OP_LOAD, 8'h13);
    rom[1] = op(OP_SUB, 8'h11);
    dmem[8'h13] = 8'h80;
    dmem[8'h11] = 8'h01;
    do_reset();
    run_to_halt("sovf_halt", cyc);
    check("sovf_cycles", 32'(cyc),          32'd8);
    check("sovf_acc",    32'(mem_data_out), 32'h7F);
    check("sovf_flag",   32'(ovf),          32'd1);

    // JZ taken on zero, not taken on nonzero, then JMP
    clear_mems();
    rom[0]     = op(OP_LOAD, 8'h30);
    rom[1]     = op(OP_SUB, 8'h31);
    rom[2]     = op(OP_JZ, 8'h40);
    rom[8'h40] = op(OP_LOAD, 8'h32);
    rom[8'h41] = op(OP_JZ, 8'h60);
    rom[8'h42] = op(OP_JMP, 8'h50);
    dmem[8'h30] = 8'd9;
    dmem[8'h31] = 8'd9;
    dmem[8'h32] = 8'd3;
    do_reset();
    run_to_halt("jz_halt", cyc);
    check("jz_cycles", 32'(cyc),          32'd17);
    check("jz_pc",     32'(instr_addr),   32'h50);
    check("jz_acc",    32'(mem_data_out), 32'd3);
    check("jz_zero",   32'(zero),         32'd0);

    // PC wrap on NOP at 0xFF, HALT freeze, stray acks outside WAIT ignored
    clear_mems();
    rom[0]     = op(OP_JZ, 8'hFE);
    rom[8'hFE] = op(OP_LOAD, 8'h70);
    rom[8'hFF] = op(OP_NOP, 8'h00);
    rom[1]     = op(OP_HALT, 8'h00);
    dmem[8'h70] = 8'd1;
    spur_ack = 1'b1;
    do_reset();
    run_to_halt("wrap_halt", cyc);
    check("wrap_pc", 32'(instr_addr), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("halt_flag", 32'(halted),     32'd1);
      check("halt_pc",   32'(instr_addr), 32'd1);
      check("halt_req",  32'(mem_req),    32'd0);
    end
    check("spur_acc", 32'(mem_data_out), 32'd1);
    spur_ack = 1'b0;
    @(negedge clk);

    // Reset while waiting for ack
    clear_mems();
    rom[0] = op(OP_LOAD, 8'h05);
    rom[1] = op(OP_ADD, 8'h06);
    dmem[5] = 8'd7;
    dmem[6] = 8'hFD;
    ack_delay = 0;
    do_reset();
    cyc = 0;
    while (instr_addr != 8'd1 && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
    check("mrst_pc1", 32'(instr_addr), 32'd1);
    ack_delay = 20;
    cyc = 0;
    while (!mem_req && cyc < TIMEOUT) begin
      tick();
      cyc++;
    end
    check("mrst_req_up", 32'(mem_req), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mrst_req",    32'(mem_req),      32'd0);
    check("mrst_acc",    32'(mem_data_out), 32'd0);
    check("mrst_pc",     32'(instr_addr),   32'd0);
    check("mrst_zero",   32'(zero),         32'd1);
    @(negedge clk);
    ack_delay = 0;
    rst = 1'b0;
    tick();
    check("mrst_fetch_req", 32'(mem_req), 32'd0);
    tick();
    check("mrst_exec_req",  32'(mem_req),  32'd1);
    check("mrst_exec_addr", 32'(mem_addr), 32'd5);
    run_to_halt("mrst_halt", cyc);
    check("mrst_final_acc", 32'(mem_data_out), 32'd4);
    check("mrst_final_pc",  32'(instr_addr),   32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/acc_core.md
ACC_CORE -- requirements
Module: acc_core

Interface
REQ-001 Parameter DATA_W, default 32, accumulator and data-memory word width; signed two's complement.
REQ-002 Parameter ADDR_W, default 8, width of program counter and data address.
REQ-003 Parameter OPC_W, default 3, opcode field width; instruction width IW = OPC_W+ADDR_W, opcode in MSBs.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 instr  in  IW  instruction word, valid combinationally for current instr_addr.
REQ-007 instr_addr  out  ADDR_W  program counter.
REQ-008 mem_req  out  1  data-memory request, held until acknowledged.
REQ-009 mem_wr  out  1  1 = write, 0 = read; valid only while mem_req=1.
REQ-010 mem_addr  out  ADDR_W  data address (operand field of latched instruction).
REQ-011 mem_data_out  out  DATA_W  write data, equal to acc.
REQ-012 mem_ack  in  1  memory completion; read data valid on mem_data_in in same cycle.
REQ-013 mem_data_in  in  DATA_W  read data.
REQ-014 zero  out  1  acc==0.
REQ-015 ovf  out  1  sticky signed overflow flag.
REQ-016 halted  out  1  core in HALT state.

Function
REQ-017 Opcodes SHALL be: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 STORE, 5 JMP, 6 JZ, 7 HALT.
REQ-018 FSM states SHALL be FETCH, EXEC, WAIT, HALT.
REQ-019 FETCH: latch instr into ir, go EXEC; one cycle.
REQ-020 EXEC, LOAD/ADD/SUB: assert mem_req=1, mem_wr=0, go WAIT.
REQ-021 EXEC, STORE: assert mem_req=1, mem_wr=1, go WAIT.
REQ-022 EXEC, NOP: pc<=pc+1, go FETCH.
REQ-023 EXEC, JMP: pc<=operand, go FETCH.
REQ-024 EXEC, JZ: pc<=operand if acc==0, else pc<=pc+1; go FETCH.
REQ-025 EXEC, HALT: go HALT; pc unchanged.
REQ-026 WAIT: hold mem_req, mem_wr, mem_addr, mem_data_out stable until mem_ack=1.
REQ-027 On mem_ack in WAIT: LOAD acc<=mem_data_in; ADD acc<=acc+mem_data_in; SUB acc<=acc-mem_data_in; STORE acc unchanged; then pc<=pc+1, mem_req<=0, go FETCH.
REQ-028 ADD/SUB SHALL wrap modulo 2^DATA_W; ovf set when operand signs and result sign indicate signed overflow; ovf cleared only by reset.
REQ-029 Non-memory instruction latency SHALL be 2 cycles; memory instruction latency 2 cycles plus wait cycles (minimum 3 with same-cycle ack in WAIT).
REQ-030 pc increment SHALL wrap from 2^ADDR_W-1 to 0.
REQ-031 mem_ack outside WAIT SHALL be ignored.
REQ-032 HALT SHALL be left only by reset; mem_req=0 in HALT.
REQ-033 zero SHALL be combinational from acc; halted combinational from state.

Reset
REQ-034 On rst: state=FETCH, pc=0, acc=0, ir=0, ovf=0, mem_req=0, mem_wr=0; zero=1, halted=0.
REQ-035 Reset mid-transaction SHALL drop mem_req immediately (asynchronously); no acc or pc update from that transaction.

Structure
REQ-036 Package acc_pkg SHALL hold opcode constants and FSM state encoding.
REQ-037 Sub-module acc_decode SHALL map opcode to is_mem, is_wr, alu_op, is_jmp, is_jz, is_halt; purely combinational.
REQ-038 Accumulator, flags, pc and FSM SHALL reside in acc_core.

Verification
REQ-039 LOAD 5 (mem[5]=7), ADD 6 (mem[6]=-3), STORE 9, ack same cycle -> mem[9]=4, pc=3, zero=0.
REQ-040 LOAD with ack delayed 4 cycles -> mem_req, mem_addr stable 4 cycles, acc updates only on ack cycle.
REQ-041 DATA_W=8: LOAD 127, ADD 1 -> acc=-128, ovf=1; subsequent SUB leaves ovf=1.
REQ-042 SUB to acc=0 then JZ 0x40 -> pc=0x40; acc nonzero then JZ -> pc+1.
REQ-043 NOP at pc=255 (ADDR_W=8) -> pc=0; HALT -> halted=1, pc frozen, mem_req=0 for 10 cycles.
REQ-044 rst asserted in WAIT -> mem_req=0 same cycle, acc=0, pc=0, state FETCH after release.
